// File: rtl/edc_pkg.sv
// Shared definitions for the SEC-DED read-path checker: check-width lookup,
// Hsiao H-matrix generation and the syndrome classification enum.
package edc_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_CHK_W  = 8;

  // One H column (check-bit pattern) per data bit; unused entries are zero.
  typedef logic [MAX_DATA_W-1:0][MAX_CHK_W-1:0] h_matrix_t;

  typedef enum logic [1:0] {
    CLEAN,
    CE_DATA,
    CE_CHK,
    UE
  } syn_class_e;

  function automatic int unsigned chk_w(input int unsigned data_w);
    case (data_w)
      16:      return 6;
      64:      return 8;
      default: return 7;
    endcase
  endfunction

  function automatic int unsigned ones8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (v[b]) n++;
    end
    return n;
  endfunction

  // Data columns: every weight-3 pattern in ascending value, then weight-5,
  // and so on, until DATA_W distinct odd-weight (>=3) columns are assigned.
  function automatic h_matrix_t h_matrix(input int unsigned data_w);
    h_matrix_t   m;
    int unsigned n;
    int unsigned cw;
    m  = '0;
    n  = 0;
    cw = chk_w(data_w);
    for (int unsigned w = 3; w <= cw; w += 2) begin
      for (int unsigned v = 0; v < (32'd1 << cw); v++) begin
        if (ones8(8'(v)) == w && n < data_w) begin
          m[n] = 8'(v);
          n++;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [MAX_CHK_W-1:0] h_col(input int unsigned data_w,
                                                 input int unsigned idx);
    h_matrix_t m;
    m = h_matrix(data_w);
    return m[idx];
  endfunction

endpackage

// File: rtl/edc_check_pipe_if.sv
// Bus bundle for edc_check_pipe: input/output streams, scrub port and status.
interface edc_check_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CHK_W = edc_pkg::chk_w(DATA_W);

  logic              edc_en;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_ce;
  logic              out_ue;
  logic              scrub_req;
  logic              scrub_ack;
  logic [ADDR_W-1:0] scrub_addr;
  logic [DATA_W-1:0] scrub_data;
  logic [CHK_W-1:0]  scrub_chk;
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  ue_cnt;
  logic              log_valid;
  logic [ADDR_W-1:0] log_addr;
  logic              log_ue;
  logic              scrub_ovf;
  logic              clr;

  modport master (
    output edc_en, in_valid, in_addr, in_data, in_chk, out_ready, scrub_ack, clr,
    input  in_ready, out_valid, out_data, out_ce, out_ue, scrub_req, scrub_addr,
           scrub_data, scrub_chk, ce_cnt, ue_cnt, log_valid, log_addr, log_ue, scrub_ovf
  );

  modport slave (
    input  edc_en, in_valid, in_addr, in_data, in_chk, out_ready, scrub_ack, clr,
    output in_ready, out_valid, out_data, out_ce, out_ue, scrub_req, scrub_addr,
           scrub_data, scrub_chk, ce_cnt, ue_cnt, log_valid, log_addr, log_ue, scrub_ovf
  );
endinterface

// File: rtl/edc_encode.sv
// Combinational Hsiao check-bit generator for a DATA_W-bit word.
module edc_encode
  import edc_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]        data_i,
  output logic [chk_w(DATA_W)-1:0] chk_o
);
  localparam int unsigned CHK_W = chk_w(DATA_W);
  localparam h_matrix_t   H     = h_matrix(DATA_W);

  // Each check bit is the parity of the data bits whose column has that row set.
  always_comb begin
    chk_o = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      for (int unsigned j = 0; j < CHK_W; j++) begin
        if (H[i][j]) chk_o[j] = chk_o[j] ^ data_i[i];
      end
    end
  end
endmodule

// File: rtl/edc_check_pipe.sv
// Two-stage SEC-DED check/correct for the memory read return path, with
// saturating error counters, first-error log and a one-entry scrub request.
module edc_check_pipe
  import edc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic             i_clk,
  input logic             i_rst_n,
  edc_check_pipe_if.slave bus
);
  localparam int unsigned CHK_W = chk_w(DATA_W);
  localparam h_matrix_t   H     = h_matrix(DATA_W);

  logic [CHK_W-1:0]  enc_chk, syn_in;
  logic              in_ready, s2_ready, xfer_out, ce_evt, ue_evt;
  logic              v1_q, byp1_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [DATA_W-1:0] data1_q;
  logic [CHK_W-1:0]  syn1_q;
  logic              v2_q, ce2_q, ue2_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [DATA_W-1:0] data2_q;
  syn_class_e        dec_class;
  logic [DATA_W-1:0] dec_data;
  logic              dec_ce, dec_ue;
  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
  logic              log_valid_q, log_valid_d, log_ue_q, log_ue_d;
  logic [ADDR_W-1:0] log_addr_q, log_addr_d, scrub_addr_q, scrub_addr_d;
  logic [DATA_W-1:0] scrub_data_q, scrub_data_d;
  logic              scrub_req_q, scrub_req_d, scrub_ovf_q, scrub_ovf_d;

  edc_encode #(.DATA_W(DATA_W)) u_enc_syn (.data_i(bus.in_data), .chk_o(enc_chk));
  assign syn_in = enc_chk ^ bus.in_chk;

  assign s2_ready = ~v2_q | bus.out_ready;
  assign in_ready = ~v1_q | s2_ready;
  assign xfer_out = v2_q & bus.out_ready;
  assign ce_evt   = xfer_out & ce2_q;
  assign ue_evt   = xfer_out & ue2_q;

  // Stage 1: capture address, raw data, syndrome and the bypass mode.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      byp1_q  <= 1'b0;
      addr1_q <= '0;
      data1_q <= '0;
      syn1_q  <= '0;
    end else if (in_ready) begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        byp1_q  <= ~bus.edc_en;
        addr1_q <= bus.in_addr;
        data1_q <= bus.in_data;
        syn1_q  <= syn_in;
      end
    end
  end

  // Classify the syndrome and flip the data bit whose column it matches.
  always_comb begin
    dec_class = CLEAN;
    dec_data  = data1_q;
    if (syn1_q != '0) begin
      dec_class = $onehot(syn1_q) ? CE_CHK : UE;
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (H[i] == MAX_CHK_W'(syn1_q)) begin
          dec_data[i] = ~data1_q[i];
          dec_class   = CE_DATA;
        end
      end
    end
  end

  assign dec_ce = ~byp1_q & ((dec_class == CE_DATA) | (dec_class == CE_CHK));
  assign dec_ue = ~byp1_q & (dec_class == UE);

  // Stage 2: hold the corrected word until downstream takes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v2_q    <= 1'b0;
      ce2_q   <= 1'b0;
      ue2_q   <= 1'b0;
      addr2_q <= '0;
      data2_q <= '0;
    end else if (s2_ready) begin
      v2_q <= v1_q;
      if (v1_q) begin
        ce2_q   <= dec_ce;
        ue2_q   <= dec_ue;
        addr2_q <= addr1_q;
        data2_q <= byp1_q ? data1_q : dec_data;
      end
    end
  end

  // Counters, log and scrub slot react to words leaving stage 2; clear wins.
  always_comb begin
    ce_cnt_d     = ce_cnt_q;
    ue_cnt_d     = ue_cnt_q;
    log_valid_d  = log_valid_q;
    log_addr_d   = log_addr_q;
    log_ue_d     = log_ue_q;
    scrub_req_d  = scrub_req_q;
    scrub_addr_d = scrub_addr_q;
    scrub_data_d = scrub_data_q;
    scrub_ovf_d  = scrub_ovf_q;
    if (ce_evt && ce_cnt_q != '1) ce_cnt_d = ce_cnt_q + 1'b1;
    if (ue_evt && ue_cnt_q != '1) ue_cnt_d = ue_cnt_q + 1'b1;
    if (!log_valid_q && (ce_evt || ue_evt)) begin
      log_valid_d = 1'b1;
      log_addr_d  = addr2_q;
      log_ue_d    = ue2_q;
    end
    if (bus.scrub_ack) scrub_req_d = 1'b0;
    // An ack in the same cycle frees the slot, so the new scrub may reload it.
    if (ce_evt) begin
      if (!scrub_req_q || bus.scrub_ack) begin
        scrub_req_d  = 1'b1;
        scrub_addr_d = addr2_q;
        scrub_data_d = data2_q;
      end else begin
        scrub_ovf_d = 1'b1;
      end
    end
    if (bus.clr) begin
      ce_cnt_d    = '0;
      ue_cnt_d    = '0;
      log_valid_d = 1'b0;
      log_addr_d  = '0;
      log_ue_d    = 1'b0;
      scrub_ovf_d = 1'b0;
    end
  end

  // Status and scrub registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ce_cnt_q     <= '0;
      ue_cnt_q     <= '0;
      log_valid_q  <= 1'b0;
      log_addr_q   <= '0;
      log_ue_q     <= 1'b0;
      scrub_req_q  <= 1'b0;
      scrub_addr_q <= '0;
      scrub_data_q <= '0;
      scrub_ovf_q  <= 1'b0;
    end else begin
      ce_cnt_q     <= ce_cnt_d;
      ue_cnt_q     <= ue_cnt_d;
      log_valid_q  <= log_valid_d;
      log_addr_q   <= log_addr_d;
      log_ue_q     <= log_ue_d;
      scrub_req_q  <= scrub_req_d;
      scrub_addr_q <= scrub_addr_d;
      scrub_data_q <= scrub_data_d;
      scrub_ovf_q  <= scrub_ovf_d;
    end
  end

  edc_encode #(.DATA_W(DATA_W)) u_enc_scrub (.data_i(scrub_data_q), .chk_o(bus.scrub_chk));

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = v2_q;
  assign bus.out_data   = data2_q;
  assign bus.out_ce     = ce2_q;
  assign bus.out_ue     = ue2_q;
  assign bus.scrub_req  = scrub_req_q;
  assign bus.scrub_addr = scrub_addr_q;
  assign bus.scrub_data = scrub_data_q;
  assign bus.ce_cnt     = ce_cnt_q;
  assign bus.ue_cnt     = ue_cnt_q;
  assign bus.log_valid  = log_valid_q;
  assign bus.log_addr   = log_addr_q;
  assign bus.log_ue     = log_ue_q;
  assign bus.scrub_ovf  = scrub_ovf_q;
endmodule

// File: tb/tb_edc_check_pipe.sv
// Directed bench for edc_check_pipe (DATA_W=32, CNT_W=2).
module tb_edc_check_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  edc_check_pipe_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(2)) bus ();

  edc_check_pipe #(.DATA_W(32), .ADDR_W(32), .CNT_W(2)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Hand-derived H columns: weight-3 7-bit patterns in ascending order.
  logic [6:0] hcol [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  function automatic logic [6:0] tb_chk(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) c = c ^ hcol[i];
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push one word into an empty pipe, check 2-cycle latency, capture outputs,
  // then let it transfer (optionally with a clear pulse on that same edge).
  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic [6:0] c,
                           input bit with_clr,
                           output logic [31:0] od, output logic oce, output logic oue);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_chk   = c;
    step();
    bus.in_valid = 1'b0;
    check("latency_not_yet", bus.out_valid, 0);
    step();
    check("latency_valid", bus.out_valid, 1);
    od  = bus.out_data;
    oce = bus.out_ce;
    oue = bus.out_ue;
    if (with_clr) bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  initial begin
    logic [31:0] od;
    logic        oce, oue;
    logic [6:0]  chk_de;
    logic [31:0] words [8];
    int          sent, rcvd;
    bit          stalled;
    logic [31:0] held;

    rst_n         = 1'b0;
    bus.edc_en    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.in_chk    = '0;
    bus.out_ready = 1'b1;
    bus.scrub_ack = 1'b0;
    bus.clr       = 1'b0;
    chk_de        = tb_chk(32'hDEADBEEF);

    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_ce_cnt", bus.ce_cnt, 0);
    check("rst_ue_cnt", bus.ue_cnt, 0);
    check("rst_log_valid", bus.log_valid, 0);
    check("rst_scrub_req", bus.scrub_req, 0);
    check("rst_scrub_ovf", bus.scrub_ovf, 0);
    check("rst_scrub_chk", bus.scrub_chk, 0);
    rst_n = 1'b1;

    // Single data-bit error (bit 5).
    send_word(32'h100, 32'hDEADBEEF ^ 32'h20, chk_de, 0, od, oce, oue);
    check("ce5_data", od, 32'hDEADBEEF);
    check("ce5_ce", oce, 1);
    check("ce5_ue", oue, 0);
    check("ce5_cnt", bus.ce_cnt, 1);
    check("ce5_ue_cnt", bus.ue_cnt, 0);
    check("ce5_log_valid", bus.log_valid, 1);
    check("ce5_log_addr", bus.log_addr, 32'h100);
    check("ce5_log_ue", bus.log_ue, 0);
    check("ce5_scrub_req", bus.scrub_req, 1);
    check("ce5_scrub_addr", bus.scrub_addr, 32'h100);
    check("ce5_scrub_data", bus.scrub_data, 32'hDEADBEEF);
    check("ce5_scrub_chk", bus.scrub_chk, chk_de);
    check("ce5_drained", bus.out_valid, 0);
    bus.scrub_ack = 1'b1;
    step();
    bus.scrub_ack = 1'b0;
    check("ce5_ack_clears", bus.scrub_req, 0);

    // Single check-bit error: data untouched, still corrected.
    send_word(32'h104, 32'hDEADBEEF, chk_de ^ 7'h04, 0, od, oce, oue);
    check("cechk_data", od, 32'hDEADBEEF);
    check("cechk_ce", oce, 1);
    check("cechk_ue", oue, 0);
    check("cechk_cnt", bus.ce_cnt, 2);
    check("cechk_log_keep", bus.log_addr, 32'h100);
    check("cechk_scrub_chk", bus.scrub_chk, chk_de);
    bus.scrub_ack = 1'b1;
    step();
    bus.scrub_ack = 1'b0;

    // Clean word.
    send_word(32'h108, 32'hDEADBEEF, chk_de, 0, od, oce, oue);
    check("clean_data", od, 32'hDEADBEEF);
    check("clean_ce", oce, 0);
    check("clean_ue", oue, 0);
    check("clean_cnt", bus.ce_cnt, 2);
    check("clean_no_scrub", bus.scrub_req, 0);

    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("clr_ce_cnt", bus.ce_cnt, 0);
    check("clr_log", bus.log_valid, 0);

    // Double error (bits 0 and 31).
    send_word(32'h200, 32'hDEADBEEF ^ 32'h80000001, chk_de, 0, od, oce, oue);
    check("ue_data", od, 32'h5EADBEEE);
    check("ue_ce", oce, 0);
    check("ue_ue", oue, 1);
    check("ue_cnt", bus.ue_cnt, 1);
    check("ue_ce_cnt", bus.ce_cnt, 0);
    check("ue_no_scrub", bus.scrub_req, 0);
    check("ue_log_valid", bus.log_valid, 1);
    check("ue_log_addr", bus.log_addr, 32'h200);
    check("ue_log_ue", bus.log_ue, 1);

    // A later error must not overwrite the log.
    send_word(32'h300, 32'hDEADBEEF ^ 32'h00010000, chk_de, 0, od, oce, oue);
    check("ce16_ce", oce, 1);
    check("log_sticky_addr", bus.log_addr, 32'h200);
    check("log_sticky_ue", bus.log_ue, 1);
    check("ce16_cnt", bus.ce_cnt, 1);
    bus.scrub_ack = 1'b1;
    step();
    bus.scrub_ack = 1'b0;

    // Bypass: raw data, no flags, no side effects.
    bus.edc_en = 1'b0;
    send_word(32'h400, 32'hDEADBEEF ^ 32'h2, chk_de, 0, od, oce, oue);
    check("byp_data", od, 32'hDEADBEED);
    check("byp_ce", oce, 0);
    check("byp_ue", oue, 0);
    check("byp_ce_cnt", bus.ce_cnt, 1);
    check("byp_ue_cnt", bus.ue_cnt, 1);
    check("byp_no_scrub", bus.scrub_req, 0);
    bus.edc_en = 1'b1;

    // Eight back-to-back clean words with out_ready toggling 1,0.
    for (int k = 0; k < 8; k++) words[k] = 32'h01010101 * (k + 1);
    sent = 0;
    rcvd = 0;
    stalled = 0;
    held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_addr = 32'(sent);
        bus.in_data = words[sent];
        bus.in_chk  = tb_chk(words[sent]);
      end
      bus.out_ready = (cyc % 2 == 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("stream_word", bus.out_data, words[rcvd]);
        check("stream_ce", bus.out_ce, 0);
        rcvd++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_sent", sent, 8);
    check("stream_rcvd", rcvd, 8);
    step();
    check("stream_no_dup", bus.out_valid, 0);

    // Counter saturation at 2 bits, then clear beating a same-cycle increment.
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.scrub_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_word(32'h500 + 32'(k), 32'hDEADBEEF ^ (32'h1 << k), chk_de, 0, od, oce, oue);
    end
    check("sat_ce_cnt", bus.ce_cnt, 3);
    send_word(32'h600, 32'hDEADBEEF ^ 32'h100, chk_de, 1, od, oce, oue);
    check("clr_wins_cnt", bus.ce_cnt, 0);
    check("clr_wins_log", bus.log_valid, 0);
    check("clr_keeps_scrub", bus.scrub_req, 1);
    step();
    bus.scrub_ack = 1'b0;
    check("scrub_acked", bus.scrub_req, 0);

    // Scrub overflow: second ce while the slot is held and not acked.
    send_word(32'h700, 32'hDEADBEEF ^ 32'h8, chk_de, 0, od, oce, oue);
    check("ovf_first_req", bus.scrub_req, 1);
    check("ovf_first_addr", bus.scrub_addr, 32'h700);
    check("ovf_first_flag", bus.scrub_ovf, 0);
    send_word(32'h704, 32'hDEADBEEF ^ 32'h80, chk_de, 0, od, oce, oue);
    check("ovf_hold_req", bus.scrub_req, 1);
    check("ovf_hold_addr", bus.scrub_addr, 32'h700);
    check("ovf_hold_data", bus.scrub_data, 32'hDEADBEEF);
    check("ovf_flag", bus.scrub_ovf, 1);
    check("ovf_ce_cnt", bus.ce_cnt, 2);
    bus.scrub_ack = 1'b1;
    step();
    bus.scrub_ack = 1'b0;
    check("ovf_ack_clears", bus.scrub_req, 0);
    check("ovf_sticky", bus.scrub_ovf, 1);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    check("ovf_clr", bus.scrub_ovf, 0);

    // Reset with both stages full.
    send_word(32'h800, 32'hDEADBEEF ^ 32'h4, chk_de, 0, od, oce, oue);
    check("pre_rst_cnt", bus.ce_cnt, 1);
    check("pre_rst_log", bus.log_valid, 1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'h900;
    bus.in_data   = 32'hDEADBEEF;
    bus.in_chk    = chk_de;
    step();
    bus.in_addr   = 32'h904;
    step();
    bus.in_valid  = 1'b0;
    check("full_out_valid", bus.out_valid, 1);
    check("full_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    step();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_ce_cnt", bus.ce_cnt, 0);
    check("mid_rst_ue_cnt", bus.ue_cnt, 0);
    check("mid_rst_log", bus.log_valid, 0);
    check("mid_rst_scrub", bus.scrub_req, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    check("post_rst_no_stale", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edc_check_pipe.md
# edc_check_pipe

Pipelined, parametrised SEC-DED check-and-correct stage for the memory read path. It sits between the main-memory read-data return and the core/cache fill path. It accepts a data word plus stored check bits and address, and recomputes the syndrome. It corrects any single-bit error and flags double-bit errors. It also keeps saturating error counters and a first-error log, and issues a scrub write-back request for corrected words.

## Interface
Parameters:
- DATA_W, 32, data width; legal values 16, 32, 64.
- CHK_W, derived from DATA_W in the package (16→6, 32→7, 64→8); not overridable.
- ADDR_W, 32, address width carried with each word.
- CNT_W, 16, width of each error counter.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_edc_en  in  1  1 = check/correct; 0 = bypass.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  stage can accept a word.
- i_in_addr  in  ADDR_W  word address.
- i_in_data  in  DATA_W  raw data.
- i_in_chk  in  CHK_W  stored check bits.
- o_out_valid  out  1  output word valid.
- i_out_ready  in  1  downstream accepts.
- o_out_data  out  DATA_W  corrected data.
- o_out_ce  out  1  word had a corrected single-bit error.
- o_out_ue  out  1  word had an uncorrectable error.
- o_scrub_req  out  1  scrub write-back pending.
- i_scrub_ack  in  1  scrub accepted.
- o_scrub_addr  out  ADDR_W  scrub address.
- o_scrub_data  out  DATA_W  corrected data to write back.
- o_scrub_chk  out  CHK_W  freshly encoded check bits.
- o_ce_cnt  out  CNT_W  correctable error count.
- o_ue_cnt  out  CNT_W  uncorrectable error count.
- o_log_valid  out  1  first-error log is holding an entry.
- o_log_addr  out  ADDR_W  address of the first logged error.
- o_log_ue  out  1  logged error was uncorrectable.
- o_scrub_ovf  out  1  sticky flag: a scrub was dropped.
- i_clr  in  1  single-cycle pulse; clears counters, log and o_scrub_ovf.

## Operation
- Code: Hsiao SEC-DED with odd-weight H columns, defined per DATA_W in the package.
- Syndrome definition: syndrome = encode(data) XOR chk.
- Stage 1 registers addr, data and syndrome.
- Stage 2 decodes the syndrome:
  - zero → clean.
  - equals a data column → flip that bit, ce.
  - equals a unit (check-bit) column → data unchanged, ce.
  - nonzero even-weight, or odd-weight with no matching column → ue; data passes uncorrected.
- Bypass (i_edc_en=0, sampled at stage-1 entry and carried with the word): ce=ue=0, no counting, no log, no scrub.
- Counters increment by one per word leaving stage 2 with ce (resp. ue). They saturate at all-ones; there is no wrap.
- Log: captures the first ce or ue while o_log_valid=0; further errors never overwrite it.
- Scrub: a one-entry holding register, loaded by a ce word leaving stage 2.
  - If the register is occupied and is not being acked in the same cycle, the new scrub is dropped and o_scrub_ovf is set.
  - ue words are never scrubbed.
- i_clr: takes priority over a same-cycle increment or capture; the result is zero or empty.
  - It does not affect the pipeline or a pending scrub.

## Timing
- Latency is 2 cycles from input acceptance to o_out_valid. Throughput is one word per cycle when i_out_ready=1.
- Handshakes:
  - stage2_ready = ~v2 | i_out_ready.
  - o_in_ready = ~v1 | stage2_ready.
  - A transfer occurs when valid & ready. Outputs hold stable while valid & ~ready.
- o_out_ce, o_out_ue and o_out_data are valid only with o_out_valid.
- Counter, log and scrub updates happen in the cycle the word transfers out; they are visible on the next cycle.
- Scrub handshake: o_scrub_req is held until the cycle with i_scrub_ack=1, and clears on the following cycle unless it is reloaded in the same cycle.
- Reset values: every valid/req/flag = 0; counters = 0; data, address and check outputs = 0.
- Reset mid-operation discards in-flight words and any pending scrub.

## Structure
- Package edc_pkg contains:
  - CHK_W lookup function.
  - H-matrix column function per DATA_W.
  - Syndrome-class enum: CLEAN, CE_DATA, CE_CHK, UE.
- Sub-module edc_encode (combinational, DATA_W parameter) is instantiated twice: once for syndrome generation and once for scrub check regeneration.

## Test plan
- DATA_W=32; 32'hDEADBEEF with correct chk; bit 5 flipped → o_out_data=32'hDEADBEEF, o_out_ce=1, o_ce_cnt=1, log captures the address, o_scrub_req with o_scrub_data=32'hDEADBEEF.
- Bits 0 and 31 flipped → o_out_ue=1, data equals the flipped input, o_ue_cnt=1, no scrub, o_log_ue=1.
- 8 back-to-back clean words with i_out_ready toggling 1,0 → all 8 words out in order, none lost or duplicated, stable while stalled.
- CNT_W=2; 5 single-bit errors → o_ce_cnt=3; i_clr in the same cycle as the 6th error → o_ce_cnt=0.
- Two ce words with i_scrub_ack=0 → first scrub held, o_scrub_ovf=1; ack → o_scrub_req=0.
- Reset asserted with both stages full → next cycle all valids, counters and o_log_valid=0.
